// File: rtl/tri_mem_pkg.sv
// Shared triangle-memory types: word and triangle widths, and the 12-word triangle record.
// Imported by the arbiter, the streamers and the triangle memory.
package tri_mem_pkg;
  localparam int D_BITS    = 32;
  localparam int M_BITS    = 12;
  localparam int TRI_WORDS = 12;

  typedef logic signed [D_BITS-1:0] word_t;
  typedef word_t [TRI_WORDS-1:0]    tri_t;

  localparam word_t TRI_MAX = {1'b0, {(D_BITS-1){1'b1}}};
endpackage

// File: rtl/tri_mem_arbiter_if.sv
// Streamer/memory bundle around the triangle-memory arbiter.
// TRI_MEM_ARB_PERF_EN adds the per-requester grant/wait counters.
interface tri_mem_arbiter_if #(
  parameter int N_REQ = 4
);
  import tri_mem_pkg::*;

  logic [N_REQ-1:0]             req;
  logic [N_REQ-1:0][M_BITS-1:0] req_addr;
  logic [N_REQ-1:0]             gnt;
  logic [N_REQ-1:0]             rd_valid;
  tri_t                         rd_data;
  logic                         mem_en;
  logic [M_BITS-1:0]            mem_addr;
  tri_t                         mem_data;

`ifdef TRI_MEM_ARB_PERF_EN
  logic [N_REQ-1:0][31:0]       grant_cnt;
  logic [N_REQ-1:0][31:0]       wait_cnt;

  modport slave (
    input  req, req_addr, mem_data,
    output gnt, rd_valid, rd_data, mem_en, mem_addr, grant_cnt, wait_cnt
  );
  modport master (
    output req, req_addr, mem_data,
    input  gnt, rd_valid, rd_data, mem_en, mem_addr, grant_cnt, wait_cnt
  );
`else
  modport slave (
    input  req, req_addr, mem_data,
    output gnt, rd_valid, rd_data, mem_en, mem_addr
  );
  modport master (
    output req, req_addr, mem_data,
    input  gnt, rd_valid, rd_data, mem_en, mem_addr
  );
`endif
endinterface

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first eligible index scanning from ptr_i upward, wrapping.
// Zero latency; win_o is one-hot or all-zero with any_o low.
module rr_pick #(
  parameter int N_REQ = 4
) (
  input  logic [N_REQ-1:0]         elig_i,
  input  logic [$clog2(N_REQ)-1:0] ptr_i,
  output logic [N_REQ-1:0]         win_o,
  output logic                     any_o
);
  localparam int IW = $clog2(N_REQ);

  function automatic logic [IW-1:0] idx(input logic [IW-1:0] p, input int k);
    return IW'((int'(p) + k) % N_REQ);
  endfunction

  logic found;

  always_comb begin
    win_o = '0;
    found = 1'b0;
    for (int k = 0; k < N_REQ; k++) begin
      if (!found && elig_i[idx(ptr_i, k)]) begin
        win_o[idx(ptr_i, k)] = 1'b1;
        found                = 1'b1;
      end
    end
    any_o = found;
  end
endmodule

// File: rtl/tri_mem_arbiter.sv
// Round-robin share of one triangle-memory read port among N_REQ streamers; rd_valid MEM_LAT+1 cycles after gnt.
// No return-path backpressure. TRI_MEM_ARB_PERF_EN adds saturating grant/wait counters.
module tri_mem_arbiter
  import tri_mem_pkg::*;
#(
  parameter int N_REQ   = 4,
  parameter int MEM_LAT = 1
) (
  input  logic             clock,
  input  logic             reset,
  tri_mem_arbiter_if.slave bus
);
  localparam int IW = $clog2(N_REQ);

  typedef struct packed {
    logic          vld;
    logic [IW-1:0] id;
  } pipe_t;

  logic [N_REQ-1:0]  gnt_q, gnt_d, rd_valid_q, rd_valid_d, elig, win;
  logic              any, mem_en_q, mem_en_d;
  logic [M_BITS-1:0] mem_addr_q, mem_addr_d, win_addr;
  logic [IW-1:0]     ptr_q, ptr_d, win_idx;
  tri_t              rd_data_q, rd_data_d;
  pipe_t [MEM_LAT:0] pipe_q, pipe_d;

  // The requester already holding gnt is masked so one request is never served twice.
  assign elig = bus.req & ~gnt_q;

  rr_pick #(.N_REQ(N_REQ)) u_pick (
    .elig_i (elig),
    .ptr_i  (ptr_q),
    .win_o  (win),
    .any_o  (any)
  );

  always_comb begin
    win_idx  = '0;
    win_addr = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (win[i]) begin
        win_idx  = IW'(i);
        win_addr = bus.req_addr[i];
      end
    end
  end

  always_comb begin
    gnt_d      = win;
    mem_en_d   = any;
    mem_addr_d = any ? win_addr : mem_addr_q;
    ptr_d      = ptr_q;
    if (any) ptr_d = (win_idx == IW'(N_REQ - 1)) ? '0 : win_idx + 1'b1;

    pipe_d        = '0;
    pipe_d[0].vld = any;
    pipe_d[0].id  = win_idx;
    for (int k = 1; k <= MEM_LAT; k++) pipe_d[k] = pipe_q[k-1];

    rd_valid_d = '0;
    rd_data_d  = rd_data_q;
    if (pipe_q[MEM_LAT].vld) begin
      rd_valid_d[pipe_q[MEM_LAT].id] = 1'b1;
      rd_data_d                      = bus.mem_data;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      gnt_q      <= '0;
      rd_valid_q <= '0;
      rd_data_q  <= '0;
      mem_en_q   <= 1'b0;
      mem_addr_q <= '0;
      ptr_q      <= '0;
      pipe_q     <= '0;
    end else begin
      gnt_q      <= gnt_d;
      rd_valid_q <= rd_valid_d;
      rd_data_q  <= rd_data_d;
      mem_en_q   <= mem_en_d;
      mem_addr_q <= mem_addr_d;
      ptr_q      <= ptr_d;
      pipe_q     <= pipe_d;
    end
  end

  assign bus.gnt      = gnt_q;
  assign bus.rd_valid = rd_valid_q;
  assign bus.rd_data  = rd_data_q;
  assign bus.mem_en   = mem_en_q;
  assign bus.mem_addr = mem_addr_q;

`ifdef TRI_MEM_ARB_PERF_EN
  logic [N_REQ-1:0][31:0] grant_cnt_q, grant_cnt_d, wait_cnt_q, wait_cnt_d;

  always_comb begin
    grant_cnt_d = grant_cnt_q;
    wait_cnt_d  = wait_cnt_q;
    for (int i = 0; i < N_REQ; i++) begin
      if (win[i] && !(&grant_cnt_q[i]))                  grant_cnt_d[i] = grant_cnt_q[i] + 32'd1;
      if (bus.req[i] && !win[i] && !(&wait_cnt_q[i]))    wait_cnt_d[i]  = wait_cnt_q[i] + 32'd1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      grant_cnt_q <= '0;
      wait_cnt_q  <= '0;
    end else begin
      grant_cnt_q <= grant_cnt_d;
      wait_cnt_q  <= wait_cnt_d;
    end
  end

  assign bus.grant_cnt = grant_cnt_q;
  assign bus.wait_cnt  = wait_cnt_q;
`endif
endmodule
